// File: rtl/delay_arbiter_if.sv
// delay_arbiter_if: requester-side bus of the shared delay timer
//   req  : per-requester timer request, held until its done pulse
//   dly  : packed per-requester delay in ticks, CNT_W bits each
//   gnt  : one-hot grant for the whole service
//   done : one-cycle expiry pulse to the served requester
//   busy : arbiter not idle
//   tick : prescaler wrap pulse
interface delay_arbiter_if #(parameter int NREQ = 4, parameter int CNT_W = 8);
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] dly;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic                  tick;
  modport master (output req, dly, input gnt, done, busy, tick);
  modport slave  (input req, dly, output gnt, done, busy, tick);
endinterface

// File: rtl/delay_arbiter.sv
// delay_arbiter: round-robin shared prescaled delay timer
//   iclk  : system clock
//   reset : asynchronous active-high reset
//   bus   : delay_arbiter_if slave (req/dly in, gnt/done/busy/tick out)
module delay_arbiter #(
  parameter int NREQ     = 4,
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 8
) (
  input logic             iclk,
  input logic             reset,
  delay_arbiter_if.slave  bus
);
  localparam int IW = $clog2(NREQ);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [PW-1:0]    pre;
  logic [CNT_W-1:0] rem;
  logic [IW-1:0]    rr, win, pick, nxt;
  logic [NREQ-1:0]  gnt, done;
  logic             found, tick;
  int               j;
  assign tick     = pre == PW'(TICK_DIV - 1);
  assign nxt      = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
  assign bus.gnt  = gnt;
  assign bus.done = done;
  assign bus.busy = state != IDLE;
  assign bus.tick = tick;
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr) + k) % NREQ;
      if (!found && bus.req[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end
  // A zero delay still spends one RUN cycle so done lands two cycles after the request.
  always_ff @(posedge iclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pre   <= '0;
      rem   <= '0;
      rr    <= '0;
      win   <= '0;
      gnt   <= '0;
      done  <= '0;
    end else begin
      pre  <= tick ? '0 : pre + 1'b1;
      done <= '0;
      case (state)
        IDLE: begin
          gnt <= '0;
          if (found) begin
            state <= RUN;
            win   <= pick;
            gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
            rem   <= bus.dly[pick*CNT_W +: CNT_W];
            pre   <= '0;
          end
        end
        RUN: begin
          if (!bus.req[win]) begin
            state <= IDLE;
            gnt   <= '0;
            rr    <= nxt;
          end else if (rem == '0 || (tick && rem == CNT_W'(1))) begin
            state <= DONE;
            done  <= gnt;
          end
          if (tick && rem != '0) rem <= rem - 1'b1;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          rr    <= nxt;
        end
      endcase
    end
  end
endmodule
